// File: rtl/udp_rx_parser_pkg.sv
// Shared types and constants for the UDP receive path.
package udp_rx_parser_pkg;

  localparam logic [7:0]  UDP_PROTOCOL = 8'h11;
  localparam logic [15:0] UDP_HDR_LEN  = 16'd8;
  localparam int          ERR_CNT_W    = 8;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    USER_DATA,
    WAIT_END
  } udp_rx_state_type;

endpackage

// File: rtl/udp_rx_parser_if.sv
// Bundles the IPv4-side input stream and the user-side UDP output stream.
interface udp_rx_parser_if;
  import udp_rx_parser_pkg::*;

  logic                 ip_rx_hdr_is_valid;
  logic [7:0]           ip_rx_hdr_protocol;
  logic [15:0]          ip_rx_hdr_data_length;
  logic [31:0]          ip_rx_hdr_src_ip_addr;
  logic [7:0]           data_in;
  logic                 data_in_valid;
  logic                 data_in_last;

  logic                 udp_rx_start;
  logic                 udp_rx_hdr_is_valid;
  logic [31:0]          udp_rx_hdr_src_ip_addr;
  logic [15:0]          udp_rx_hdr_src_port;
  logic [15:0]          udp_rx_hdr_dst_port;
  logic [15:0]          udp_rx_hdr_data_length;
  logic [7:0]           data_out;
  logic                 data_out_valid;
  logic                 data_out_last;
  logic [ERR_CNT_W-1:0] err_count;

  // Parser side: consumes the IPv4 stream, produces the UDP stream.
  modport slave (
    input  ip_rx_hdr_is_valid, ip_rx_hdr_protocol, ip_rx_hdr_data_length,
           ip_rx_hdr_src_ip_addr, data_in, data_in_valid, data_in_last,
    output udp_rx_start, udp_rx_hdr_is_valid, udp_rx_hdr_src_ip_addr,
           udp_rx_hdr_src_port, udp_rx_hdr_dst_port, udp_rx_hdr_data_length,
           data_out, data_out_valid, data_out_last, err_count
  );

  // Environment side: drives the IPv4 stream, observes the UDP stream.
  modport master (
    output ip_rx_hdr_is_valid, ip_rx_hdr_protocol, ip_rx_hdr_data_length,
           ip_rx_hdr_src_ip_addr, data_in, data_in_valid, data_in_last,
    input  udp_rx_start, udp_rx_hdr_is_valid, udp_rx_hdr_src_ip_addr,
           udp_rx_hdr_src_port, udp_rx_hdr_dst_port, udp_rx_hdr_data_length,
           data_out, data_out_valid, data_out_last, err_count
  );

endinterface

// File: rtl/udp_rx_parser.sv
// UDP receive parser: strips the 8-byte UDP header from the IPv4 payload
// stream, publishes the decoded header and forwards the user payload with
// one cycle of latency. No backpressure; the checksum is ignored.
module udp_rx_parser
  import udp_rx_parser_pkg::*;
(
  input logic            clk,
  input logic            reset,
  udp_rx_parser_if.slave bus
);

  udp_rx_state_type     state;
  logic [2:0]           cnt;
  logic [15:0]          remaining;

  // Header fields under assembly, published together on byte 7
  logic [15:0]          src_port_p0;
  logic [15:0]          dst_port_p0;
  logic [15:0]          udp_len_p0;
  logic [31:0]          src_ip_p0;

  // Registered outputs
  logic                 start_p1;
  logic                 hdr_valid_p1;
  logic [31:0]          src_ip_p1;
  logic [15:0]          src_port_p1;
  logic [15:0]          dst_port_p1;
  logic [15:0]          data_len_p1;
  logic [7:0]           data_p1;
  logic                 vld_p1;
  logic                 last_p1;
  logic [ERR_CNT_W-1:0] err_cnt;

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] c);
    return (c == '1) ? c : c + 1'b1;
  endfunction

  function automatic logic len_bad(input logic [15:0] udp_len, input logic [15:0] ip_len);
    return (udp_len < UDP_HDR_LEN) || (udp_len > ip_len);
  endfunction

  // Parser FSM; advances only on cycles carrying a valid input byte
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      remaining    <= '0;
      start_p1     <= 1'b0;
      hdr_valid_p1 <= 1'b0;
      src_ip_p1    <= '0;
      src_port_p1  <= '0;
      dst_port_p1  <= '0;
      data_len_p1  <= '0;
      data_p1      <= '0;
      vld_p1       <= 1'b0;
      last_p1      <= 1'b0;
      err_cnt      <= '0;
    end else begin
      start_p1 <= 1'b0;
      vld_p1   <= 1'b0;
      last_p1  <= 1'b0;
      if (bus.data_in_valid) begin
        case (state)
          IDLE: begin
            if (bus.ip_rx_hdr_is_valid && bus.ip_rx_hdr_protocol == UDP_PROTOCOL) begin
              src_port_p0[15:8] <= bus.data_in;
              src_ip_p0         <= bus.ip_rx_hdr_src_ip_addr;
              hdr_valid_p1      <= 1'b0;
              cnt               <= 3'd1;
              if (bus.data_in_last) begin
                // One-byte packet: header truncated at byte 0
                err_cnt <= sat_inc(err_cnt);
              end else begin
                state <= HDR;
              end
            end else if (!bus.data_in_last) begin
              state <= WAIT_END;
            end
          end
          HDR: begin
            cnt <= cnt + 3'd1;
            case (cnt)
              3'd1:    src_port_p0[7:0]  <= bus.data_in;
              3'd2:    dst_port_p0[15:8] <= bus.data_in;
              3'd3:    dst_port_p0[7:0]  <= bus.data_in;
              3'd4:    udp_len_p0[15:8]  <= bus.data_in;
              3'd5:    udp_len_p0[7:0]   <= bus.data_in;
              default: ;
            endcase
            if (cnt == 3'd7) begin
              if (len_bad(udp_len_p0, bus.ip_rx_hdr_data_length)) begin
                err_cnt <= sat_inc(err_cnt);
                state   <= bus.data_in_last ? IDLE : WAIT_END;
              end else if (udp_len_p0 != UDP_HDR_LEN && bus.data_in_last) begin
                // Payload promised but the packet ends with the header
                err_cnt <= sat_inc(err_cnt);
                state   <= IDLE;
              end else begin
                start_p1     <= 1'b1;
                hdr_valid_p1 <= 1'b1;
                src_ip_p1    <= src_ip_p0;
                src_port_p1  <= src_port_p0;
                dst_port_p1  <= dst_port_p0;
                data_len_p1  <= udp_len_p0 - UDP_HDR_LEN;
                remaining    <= udp_len_p0 - UDP_HDR_LEN;
                if (udp_len_p0 == UDP_HDR_LEN) begin
                  state <= bus.data_in_last ? IDLE : WAIT_END;
                end else begin
                  state <= USER_DATA;
                end
              end
            end else if (bus.data_in_last) begin
              err_cnt <= sat_inc(err_cnt);
              state   <= IDLE;
            end
          end
          USER_DATA: begin
            data_p1   <= bus.data_in;
            vld_p1    <= 1'b1;
            remaining <= remaining - 16'd1;
            if (remaining == 16'd1) begin
              last_p1 <= 1'b1;
              state   <= bus.data_in_last ? IDLE : WAIT_END;
            end else if (bus.data_in_last) begin
              last_p1 <= 1'b1;
              err_cnt <= sat_inc(err_cnt);
              state   <= IDLE;
            end
          end
          WAIT_END: begin
            if (bus.data_in_last) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.udp_rx_start           = start_p1;
  assign bus.udp_rx_hdr_is_valid    = hdr_valid_p1;
  assign bus.udp_rx_hdr_src_ip_addr = src_ip_p1;
  assign bus.udp_rx_hdr_src_port    = src_port_p1;
  assign bus.udp_rx_hdr_dst_port    = dst_port_p1;
  assign bus.udp_rx_hdr_data_length = data_len_p1;
  assign bus.data_out               = data_p1;
  assign bus.data_out_valid         = vld_p1;
  assign bus.data_out_last          = last_p1;
  assign bus.err_count              = err_cnt;

endmodule

// File: doc/udp_rx_parser.md
# udp_rx_parser

Receive-side UDP layer: consumes the byte stream delivered by the IPv4 receive block, strips and decodes the 8-byte UDP header, and forwards the user payload with a decoded header to the application. It is the counterpart of the UDP transmit path and sits between the IPv4 RX block and the user receive interface. There is no backpressure: input is valid-only, and output is valid-only with fixed latency. The UDP checksum is not verified.

## Interface
- UDP_PROTOCOL, 8'h11: IPv4 protocol value accepted.
- ERR_CNT_W, 8: width of the saturating error counter.

- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- ip_rx_hdr_is_valid  in  1  IPv4 header of the current packet is valid.
- ip_rx_hdr_protocol  in  8  IPv4 protocol field.
- ip_rx_hdr_data_length  in  16  IPv4 payload length in bytes.
- ip_rx_hdr_src_ip_addr  in  32  source IP address.
- data_in  in  8  IPv4 payload byte.
- data_in_valid  in  1  data_in qualifier.
- data_in_last  in  1  last IPv4 payload byte; qualified by data_in_valid.
- udp_rx_start  out  1  one-cycle pulse when the header is decoded.
- udp_rx_hdr_is_valid  out  1  header outputs are valid.
- udp_rx_hdr_src_ip_addr  out  32
- udp_rx_hdr_src_port  out  16
- udp_rx_hdr_dst_port  out  16
- udp_rx_hdr_data_length  out  16  UDP length minus 8.
- data_out  out  8  payload byte.
- data_out_valid  out  1
- data_out_last  out  1
- err_count  out  ERR_CNT_W  saturating count of malformed packets.

## Operation
- **States:** IDLE, HDR, USER_DATA, WAIT_END.
- **Stalls:** the FSM advances only on cycles with data_in_valid=1. Gaps in valid are legal in every state and stall the FSM.
- **IDLE:**
  - On a valid byte with ip_rx_hdr_is_valid=1 and protocol==UDP_PROTOCOL: capture header byte 0, clear udp_rx_hdr_is_valid, set byte cnt=1, go to HDR.
  - On any other valid byte: go to WAIT_END. If data_in_last=1 on that byte, stay in IDLE.
- **HDR:** bytes are big-endian.
  - Bytes 0-1: src_port. Bytes 2-3: dst_port. Bytes 4-5: udp_len. Bytes 6-7: checksum, discarded.
  - udp_len is checked on byte 7 and is bad if udp_len<8 or udp_len>ip_rx_hdr_data_length.
  - Bad length: err_count++, no start, go to WAIT_END (IDLE if byte 7 also has data_in_last).
  - udp_len==8: pulse start and assert hdr_is_valid; no payload is emitted; go to WAIT_END (IDLE if last).
  - Otherwise: pulse start, load remaining=udp_len-8, go to USER_DATA.
  - data_in_last on bytes 0-7 (truncated header): err_count++, no start, go to IDLE.
- **USER_DATA:** forward each valid byte and decrement remaining.
  - data_out_last is asserted when remaining==1 or data_in_last=1.
  - remaining==1 without data_in_last: go to WAIT_END, which drops the IPv4 padding.
  - remaining==1 with data_in_last: go to IDLE.
  - data_in_last with remaining>1 (short payload): forward the byte with last, err_count++, go to IDLE.
- **WAIT_END:** discard bytes until data_in_last, then go to IDLE.
- **Header outputs:** captured at byte 7 and held until the next packet enters HDR.
- **err_count:** saturates at all-ones.
- **Reset:** mid-packet reset returns the FSM to IDLE. Remaining bytes of that packet are then handled as a new packet, so IDLE rules apply to them.

## Timing
- **Reset values:** all outputs 0, err_count 0, state IDLE.
- **Start:** if header byte 7 is accepted at cycle t, udp_rx_start and udp_rx_hdr_* are valid at t+1.
- **Data latency:** data_out is registered, 1 cycle. A byte accepted at cycle t appears at t+1, with data_out_valid matching input gaps.
- **Ordering:** with contiguous input, the first payload byte is at t+1 input and appears at output t+2, one cycle after start.
- **Back-to-back packets:** a new packet's byte 0 may arrive the cycle after the previous data_in_last. No idle cycle is required, and no byte is lost.
- **data_out_last:** accompanies exactly one data_out_valid beat per forwarded packet.

## Structure
- **Additions to the shared global types package:**
  - UDP_PROTOCOL=8'h11 and UDP_HDR_LEN=8 constants.
  - A udp_rx_state_type enum.
- Existing udp_rx_header_type, axi_in_type and ipv4_rx_type model the ports in the testbench.
- Single module; no sub-module is warranted.

## Test plan
- **Normal packet:** protocol 0x11, IP len 12, header 1234/5678/000C/0000, payload AA BB CC DD. Expect start at t+1 with src_port 0x1234, dst_port 0x5678, data_length 4. Expect AA..DD out, last on DD, err_count 0.
- **Padding:** IP len 20, udp_len 0x000A, payload 11 22 then 10 pad bytes. Expect 11 22 out, last on 22, pad bytes dropped, err_count 0.
- **Errors:**
  - udp_len 0x0004: no start, err_count 1.
  - Header cut at byte 5 by data_in_last: no start, err_count 2.
  - Payload short by 2 bytes: last on the final received byte, err_count 3.
- **Protocol filter:** a protocol 0x06 packet followed back-to-back by a UDP packet. The first produces no output; the second decodes correctly with no byte lost.
- **Gaps and zero payload:** random data_in_valid gaps produce the same bytes, each delayed by 1 cycle. udp_len 8 gives start with data_length 0 and no data_out_valid.
- **Reset:** reset mid-payload returns all outputs to 0 within 1 cycle. With err_count driven past 255 errors, it holds at 255.
